// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch (IF)
// and load/store (DP). DP has priority. After MAX_DP_STREAK back-to-back DP grants
// made while IF is waiting, the next grant goes to IF.
// Optional feature macro: MEM_ARB_ALIGN_CHECK_EN adds IF_ERR. It flags fetches that
// are misaligned or out of range; such a fetch is acknowledged but never issued.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned READ_LAT      = 1,
  parameter int unsigned MAX_DP_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IF_REQ,
  input  logic [31:0]       IF_ADDR,
  output logic              IF_ACK,
  output logic              IF_VALID,
  output logic [31:0]       IF_DATA,
`ifdef MEM_ARB_ALIGN_CHECK_EN
  output logic              IF_ERR,
`endif
  input  logic              DP_REQ,
  input  logic              DP_WE,
  input  logic [ADDR_W-1:0] DP_ADDR,
  input  logic [31:0]       DP_WDATA,
  output logic              DP_ACK,
  output logic              DP_VALID,
  output logic [31:0]       DP_RDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_STORE,
  output logic              MEM_WRITE_ENABLE,
  output logic              MEM_READ_ENB,
  input  logic [31:0]       MEM_LOAD
);

  localparam logic [3:0] MaxStreak = 4'(MAX_DP_STREAK);
  localparam logic [2:0] WaitInit  = 3'(READ_LAT - 1);

  typedef enum logic [1:0] {StIdle, StCmd, StRdWait, StRdCap} state_e;

  state_e     state_q;
  logic [3:0] streak_q;   // consecutive DP grants while IF was waiting
  logic [2:0] wait_q;     // remaining RD_WAIT cycles
  logic       is_rd_q;    // current access is a memory read
  logic       owner_dp_q; // current access belongs to DP

  logic dp_win;
  logic if_win;
  logic if_bad;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  // Fetch must be word aligned and lie inside the addressable window.
  assign if_bad = (IF_ADDR[1:0] != 2'b00) || (IF_ADDR[31:ADDR_W+2] != '0);
`else
  // Bits outside the word index are deliberately ignored.
  logic unused_if_addr;
  assign unused_if_addr = ^{IF_ADDR[31:ADDR_W+2], IF_ADDR[1:0]};
  assign if_bad         = 1'b0;
`endif

  // Winner selection: DP first, unless IF has been starved for a full streak.
  always_comb begin
    dp_win = DP_REQ && !(IF_REQ && (streak_q == MaxStreak));
    if_win = IF_REQ && !dp_win;
  end

  // Arbitration FSM with registered strobes, handshakes and return data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q          <= StIdle;
      streak_q         <= 4'd0;
      wait_q           <= 3'd0;
      is_rd_q          <= 1'b0;
      owner_dp_q       <= 1'b0;
      IF_ACK           <= 1'b0;
      IF_VALID         <= 1'b0;
      IF_DATA          <= 32'd0;
      DP_ACK           <= 1'b0;
      DP_VALID         <= 1'b0;
      DP_RDATA         <= 32'd0;
      MEM_ADDR         <= '0;
      MEM_STORE        <= 32'd0;
      MEM_WRITE_ENABLE <= 1'b0;
      MEM_READ_ENB     <= 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      IF_ERR           <= 1'b0;
`endif
    end else begin
      // Every handshake and strobe is a single-cycle pulse.
      IF_ACK           <= 1'b0;
      IF_VALID         <= 1'b0;
      DP_ACK           <= 1'b0;
      DP_VALID         <= 1'b0;
      MEM_WRITE_ENABLE <= 1'b0;
      MEM_READ_ENB     <= 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      IF_ERR           <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (dp_win) begin
            DP_ACK     <= 1'b1;
            owner_dp_q <= 1'b1;
            MEM_ADDR   <= DP_ADDR;
            state_q    <= StCmd;
            if (DP_WE) begin
              MEM_STORE        <= DP_WDATA;
              MEM_WRITE_ENABLE <= 1'b1;
              is_rd_q          <= 1'b0;
            end else begin
              MEM_READ_ENB <= 1'b1;
              is_rd_q      <= 1'b1;
            end
            if (!IF_REQ) begin
              streak_q <= 4'd0;
            end else if (streak_q != MaxStreak) begin
              streak_q <= streak_q + 4'd1;
            end
          end else if (if_win) begin
            IF_ACK     <= 1'b1;
            owner_dp_q <= 1'b0;
            streak_q   <= 4'd0;
            state_q    <= StCmd;
            if (if_bad) begin
              // Rejected fetch: acknowledge only, no memory access.
              is_rd_q <= 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
              IF_ERR  <= 1'b1;
`endif
            end else begin
              MEM_ADDR     <= IF_ADDR[ADDR_W+1:2];
              MEM_READ_ENB <= 1'b1;
              is_rd_q      <= 1'b1;
            end
          end
        end
        StCmd: begin
          if (!is_rd_q) begin
            state_q <= StIdle;
          end else if (READ_LAT == 1) begin
            state_q <= StRdCap;
          end else begin
            wait_q  <= WaitInit;
            state_q <= StRdWait;
          end
        end
        StRdWait: begin
          if (wait_q == 3'd1) begin
            state_q <= StRdCap;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
        StRdCap: begin
          // MEM_LOAD is valid in this cycle; hand it to the owner next cycle.
          if (owner_dp_q) begin
            DP_RDATA <= MEM_LOAD;
            DP_VALID <= 1'b1;
          end else begin
            IF_DATA  <= MEM_LOAD;
            IF_VALID <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven single transactions, hand-written multi-cycle
// sequences, and randomized traffic checked against a transaction-level model.
// Instance "a" uses READ_LAT=1; instance "b" uses READ_LAT=3.
module tb_mem_port_arbiter;

  localparam int LatA = 1;
  localparam int LatB = 3;
  localparam int MaxS = 4;

  logic        clk = 1'b0;
  logic        rst;
  int          checks   = 0;
  int          failures = 0;

  // DUT a signals
  logic        if_req, if_ack, if_valid, dp_req, dp_we, dp_ack, dp_valid, mem_we, mem_re;
  logic [31:0] if_addr, if_data, dp_wdata, dp_rdata, mem_store, mem_load;
  logic [15:0] dp_addr, mem_addr;
  logic        err_a;
  // DUT b signals
  logic        b_if_req, b_if_ack, b_if_valid, b_dp_req, b_dp_we, b_dp_ack, b_dp_valid;
  logic        b_mem_we, b_mem_re;
  logic [31:0] b_if_addr, b_if_data, b_dp_wdata, b_dp_rdata, b_mem_store, b_mem_load;
  logic [15:0] b_dp_addr, b_mem_addr;
  logic        err_b;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic if_err, b_if_err;
  assign err_a = if_err;
  assign err_b = b_if_err;
`else
  assign err_a = 1'b0;
  assign err_b = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .READ_LAT(LatA), .MAX_DP_STREAK(MaxS)) u_dut_a (
    .CLK(clk), .RST(rst),
    .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_ACK(if_ack), .IF_VALID(if_valid),
    .IF_DATA(if_data),
`ifdef MEM_ARB_ALIGN_CHECK_EN
    .IF_ERR(if_err),
`endif
    .DP_REQ(dp_req), .DP_WE(dp_we), .DP_ADDR(dp_addr), .DP_WDATA(dp_wdata),
    .DP_ACK(dp_ack), .DP_VALID(dp_valid), .DP_RDATA(dp_rdata),
    .MEM_ADDR(mem_addr), .MEM_STORE(mem_store), .MEM_WRITE_ENABLE(mem_we),
    .MEM_READ_ENB(mem_re), .MEM_LOAD(mem_load)
  );

  mem_port_arbiter #(.ADDR_W(16), .READ_LAT(LatB), .MAX_DP_STREAK(MaxS)) u_dut_b (
    .CLK(clk), .RST(rst),
    .IF_REQ(b_if_req), .IF_ADDR(b_if_addr), .IF_ACK(b_if_ack), .IF_VALID(b_if_valid),
    .IF_DATA(b_if_data),
`ifdef MEM_ARB_ALIGN_CHECK_EN
    .IF_ERR(b_if_err),
`endif
    .DP_REQ(b_dp_req), .DP_WE(b_dp_we), .DP_ADDR(b_dp_addr), .DP_WDATA(b_dp_wdata),
    .DP_ACK(b_dp_ack), .DP_VALID(b_dp_valid), .DP_RDATA(b_dp_rdata),
    .MEM_ADDR(b_mem_addr), .MEM_STORE(b_mem_store), .MEM_WRITE_ENABLE(b_mem_we),
    .MEM_READ_ENB(b_mem_re), .MEM_LOAD(b_mem_load)
  );

  // Memory contents: a few fixed words, otherwise {~addr, addr}.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (a == 16'h0004) return 32'hDEADBEEF;
    if (a == 16'h0100) return 32'hCAFEF00D;
    return {~a, a};
  endfunction

  // Memories return data exactly READ_LAT cycles after the strobe, junk otherwise.
  logic        a_p1, b_p1, b_p2, b_p3;
  logic [15:0] a_pa, b_pa1, b_pa2, b_pa3;
  always @(posedge clk) begin
    a_p1  <= mem_re;   a_pa  <= mem_addr;
    b_p1  <= b_mem_re; b_pa1 <= b_mem_addr;
    b_p2  <= b_p1;     b_pa2 <= b_pa1;
    b_p3  <= b_p2;     b_pa3 <= b_pa2;
  end
  assign mem_load   = a_p1 ? mem_word(a_pa)  : 32'h0BAD0BAD;
  assign b_mem_load = b_p3 ? mem_word(b_pa3) : 32'h0BAD0BAD;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_a();
    return {9'b0, err_a, if_ack, if_valid, if_data, dp_ack, dp_valid, dp_rdata,
            mem_addr, mem_store, mem_we, mem_re};
  endfunction

  function automatic logic [127:0] pack_b();
    return {9'b0, err_b, b_if_ack, b_if_valid, b_if_data, b_dp_ack, b_dp_valid, b_dp_rdata,
            b_mem_addr, b_mem_store, b_mem_we, b_mem_re};
  endfunction

  typedef struct {
    bit          use_if;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] maddr;
    logic [31:0] data;
  } vec_t;

  // One isolated transaction on DUT a, starting from IDLE.
  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    if (v.use_if) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      dp_req = 1'b1; dp_we = v.we; dp_addr = v.addr[15:0]; dp_wdata = v.wdata;
    end
    @(negedge clk);
    chk({nm, "_ack"}, {if_ack, dp_ack}, v.use_if ? 2'b10 : 2'b01);
    chk({nm, "_strobe"}, {mem_we, mem_re}, v.we ? 2'b10 : 2'b01);
    chk({nm, "_maddr"}, mem_addr, v.maddr);
    if (v.we) chk({nm, "_mstore"}, mem_store, v.wdata);
    if_req = 1'b0; dp_req = 1'b0;
    if (v.we) begin
      @(negedge clk);
      chk({nm, "_after"}, {if_ack, dp_ack, mem_we, mem_re, if_valid, dp_valid}, 6'b0);
    end else begin
      for (int k = 0; k < LatA; k++) begin
        @(negedge clk);
        chk({nm, "_novalid"}, {if_valid, dp_valid}, 2'b00);
      end
      @(negedge clk);
      chk({nm, "_valid"}, {if_valid, dp_valid}, v.use_if ? 2'b10 : 2'b01);
      chk({nm, "_data"}, v.use_if ? if_data : dp_rdata, v.data);
    end
  endtask

  // Transaction-level reference: occupancy countdown plus streak rule.
  int          m_busy, m_streak;
  bit          m_rd, m_dp;
  logic [15:0] m_addr;
  logic        e_if_ack, e_if_valid, e_dp_ack, e_dp_valid, e_we, e_re, e_err;
  logic [31:0] e_if_data, e_dp_rdata, e_mstore;
  logic [15:0] e_maddr;

  function automatic bit if_misaligned(input logic [31:0] a);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    return (a % 4 != 0) || (a >= 32'h0004_0000);
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_streak = 0; m_rd = 0; m_dp = 0; m_addr = 0;
      {e_if_ack, e_if_valid, e_dp_ack, e_dp_valid, e_we, e_re, e_err} = '0;
      e_if_data = 0; e_dp_rdata = 0; e_mstore = 0; e_maddr = 0;
    end else begin
      {e_if_ack, e_if_valid, e_dp_ack, e_dp_valid, e_we, e_re, e_err} = '0;
      if (m_busy > 0) begin
        if (m_busy == 1 && m_rd) begin
          if (m_dp) begin e_dp_valid = 1; e_dp_rdata = mem_word(m_addr); end
          else      begin e_if_valid = 1; e_if_data  = mem_word(m_addr); end
        end
        m_busy--;
      end else if (dp_req && !(if_req && m_streak == MaxS)) begin
        e_dp_ack = 1; e_maddr = dp_addr; m_dp = 1; m_addr = dp_addr;
        if (dp_we) begin e_we = 1; e_mstore = dp_wdata; m_rd = 0; m_busy = 1; end
        else       begin e_re = 1; m_rd = 1; m_busy = LatA + 1; end
        m_streak = if_req ? ((m_streak < MaxS) ? m_streak + 1 : MaxS) : 0;
      end else if (if_req) begin
        e_if_ack = 1; m_streak = 0; m_dp = 0;
        if (if_misaligned(if_addr)) begin
          e_err = 1; m_rd = 0; m_busy = 1;
        end else begin
          m_addr = 16'((if_addr >> 2) & 32'hFFFF);
          e_maddr = m_addr; e_re = 1; m_rd = 1; m_busy = LatA + 1;
        end
      end
    end
  endtask

  function automatic logic [31:0] rand_if_addr();
`ifdef MEM_ARB_ALIGN_CHECK_EN
    if ($urandom_range(0, 7) == 0) return $urandom;
    return {14'b0, 16'($urandom), 2'b00};
`else
    return $urandom;
`endif
  endfunction

  vec_t        vecs[7];
  logic [9:0]  ord;
  int          ng, ifv, dpv;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          16'h0004, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0020, 32'h12345678,   16'h0020, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,          16'h0020, 32'hFFDF0020};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,          16'h0100, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_FFFF, 32'hA5A55A5A,   16'hFFFF, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h0003_FFFC, 32'h0,          16'hFFFF, 32'h0000FFFF};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,          16'h0004, 32'hDEADBEEF};

    rst = 1'b1;
    if_req = 0; if_addr = 0; dp_req = 0; dp_we = 0; dp_addr = 0; dp_wdata = 0;
    b_if_req = 0; b_if_addr = 0; b_dp_req = 0; b_dp_we = 0; b_dp_addr = 0; b_dp_wdata = 0;
    repeat (3) @(negedge clk);
    chk("reset_a", pack_a(), 128'd0);
    chk("reset_b", pack_b(), 128'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Store occupies two cycles: a fetch raised during CMD is acked two cycles later.
    @(negedge clk);
    dp_req = 1; dp_we = 1; dp_addr = 16'h0020; dp_wdata = 32'h12345678;
    @(negedge clk);
    chk("st_ack", {dp_ack, mem_we, mem_addr, mem_store}, {2'b11, 16'h0020, 32'h12345678});
    dp_req = 0; if_req = 1; if_addr = 32'h0000_0020;
    @(negedge clk);
    chk("st_idle", {if_ack, mem_we, dp_valid}, 3'b000);
    @(negedge clk);
    chk("st_next_ack", if_ack, 1'b1);
    if_req = 0;
    repeat (2) @(negedge clk);
    chk("st_next_data", {if_valid, if_data}, {1'b1, 32'hFFF70008});

    // Both requesters held: DP x4 then IF, repeating.
    @(negedge clk);
    if_req = 1; if_addr = 32'h0000_0040; dp_req = 1; dp_we = 0; dp_addr = 16'h0010;
    ord = '0; ng = 0; ifv = 0; dpv = 0;
    for (int cyc = 0; cyc < 300 && ng < 10; cyc++) begin
      @(negedge clk);
      if (if_valid) ifv++;
      if (dp_valid) dpv++;
      if (dp_ack) begin ord[ng] = 1'b0; ng++; end
      if (if_ack) begin ord[ng] = 1'b1; ng++; end
    end
    if_req = 0; dp_req = 0;
    repeat (4) begin
      @(negedge clk);
      if (if_valid) ifv++;
      if (dp_valid) dpv++;
    end
    chk("arb_grants", ng, 10);
    chk("arb_order", ord, 10'b10_0001_0000);
    chk("arb_if_valids", ifv, 2);
    chk("arb_dp_valids", dpv, 8);

    // Reset in the cycle after the read strobe aborts the fetch.
    @(negedge clk);
    if_req = 1; if_addr = 32'h0000_0010;
    @(negedge clk);
    chk("abort_strobe", {if_ack, mem_re}, 2'b11);
    if_req = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_outputs", pack_a(), 128'd0);
    rst = 0;
    ifv = 0;
    repeat (5) begin
      @(negedge clk);
      if (if_valid) ifv++;
    end
    chk("abort_no_valid", ifv, 0);
    run_vec('{1'b1, 1'b0, 32'h0000_0104, 32'h0, 16'h0041, 32'hFFBE0041}, "post_rst");

`ifdef MEM_ARB_ALIGN_CHECK_EN
    @(negedge clk);
    if_req = 1; if_addr = 32'h0000_0002;
    @(negedge clk);
    chk("align_err", {if_ack, err_a, mem_re}, 3'b110);
    if_req = 0;
    ifv = 0;
    repeat (3) begin
      @(negedge clk);
      if (if_valid || mem_re || err_a) ifv++;
    end
    chk("align_quiet", ifv, 0);
    chk("align_data_kept", if_data, 32'hFFBE0041);
`endif

    // READ_LAT=3: DP load, fetch raised during the wait.
    @(negedge clk);
    b_dp_req = 1; b_dp_we = 0; b_dp_addr = 16'h0100;
    @(negedge clk);
    chk("lat3_issue", {b_dp_ack, b_mem_re, b_mem_addr}, {2'b11, 16'h0100});
    b_dp_req = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat3_c%0d_ifack", k), b_if_ack, 1'b0);
      chk($sformatf("lat3_c%0d_valid", k), b_dp_valid, (k == 4) ? 1'b1 : 1'b0);
      if (k == 1) begin b_if_req = 1; b_if_addr = 32'h0000_0200; end
    end
    chk("lat3_rdata", b_dp_rdata, 32'hCAFEF00D);
    @(negedge clk);
    chk("lat3_if_ack", {b_if_ack, b_mem_re, b_mem_addr}, {2'b11, 16'h0080});
    b_if_req = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat3_if_c%0d_valid", k), b_if_valid, (k == 4) ? 1'b1 : 1'b0);
    end
    chk("lat3_if_data", b_if_data, 32'hFF7F0080);

    // Randomized traffic against the reference model.
    @(negedge clk);
    rst = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("rand", pack_a(),
          {9'b0, e_err, e_if_ack, e_if_valid, e_if_data, e_dp_ack, e_dp_valid, e_dp_rdata,
           e_maddr, e_mstore, e_we, e_re});
      rst = ($urandom_range(0, 299) == 0);
      if (if_req) begin
        if (if_ack) begin
          if_req = 1'($urandom_range(0, 1));
          if_addr = rand_if_addr();
        end
      end else if ($urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = rand_if_addr();
      end
      if (dp_req) begin
        if (dp_ack) begin
          dp_req = 1'($urandom_range(0, 1));
          dp_we = 1'($urandom_range(0, 1)); dp_addr = 16'($urandom); dp_wdata = $urandom;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        dp_req = 1;
        dp_we = 1'($urandom_range(0, 1)); dp_addr = 16'($urandom); dp_wdata = $urandom;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
